// File: rtl/masked_gf4_mul_pipe_pkg.sv
// Shared constants and reference GF(2^2) functions for the masked multiplier slice.
// GF4_SCL_N_EN is consumed by the top; the reference scaling function here is always available.
package masked_gf4_mul_pipe_pkg;

   localparam int unsigned FAC_W  = 3;
   localparam int unsigned GF4_W  = 2;
   localparam int unsigned SHARES = 2;

   // Canright normal-basis product of two unmasked GF(2^2) elements {hi,lo}.
   function automatic logic [GF4_W-1:0] gf4_mul_ref(input logic [GF4_W-1:0] a,
                                                    input logic [GF4_W-1:0] b);
      logic e;
      e = (a[1] ^ a[0]) & (b[1] ^ b[0]);
      return {(a[1] & b[1]) ^ e, (a[0] & b[0]) ^ e};
   endfunction

   function automatic logic [GF4_W-1:0] gf4_scl_n_ref(input logic [GF4_W-1:0] x);
      return {x[0], x[1] ^ x[0]};
   endfunction

endpackage

// File: rtl/masked_gf4_mul_pipe_if.sv
// Valid/ready bus carrying shared factor words in and masked product shares out.
interface masked_gf4_mul_pipe_if #(
   parameter int unsigned LANES = 1
);
   logic                 in_valid;
   logic                 in_ready;
   logic [3*LANES-1:0]   a0_f;
   logic [3*LANES-1:0]   a1_f;
   logic [3*LANES-1:0]   b0_f;
   logic [3*LANES-1:0]   b1_f;
   logic [3*LANES-1:0]   rnd;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*LANES-1:0]   p0;
   logic [2*LANES-1:0]   p1;

   modport slave (
      input  in_valid, a0_f, a1_f, b0_f, b1_f, rnd, out_ready,
      output in_ready, out_valid, p0, p1
   );

   modport master (
      output in_valid, a0_f, a1_f, b0_f, b1_f, rnd, out_ready,
      input  in_ready, out_valid, p0, p1
   );
endinterface

// File: rtl/masked_gf4_mul_pipe_dom_and_2.sv
// Two-share DOM AND for one factor bit; the four registered terms form the glitch barrier
// between domains, so they must survive synthesis untouched.
module masked_gf4_mul_pipe_dom_and_2 (
   input  logic clk,
   input  logic rst_n,
   input  logic x0,
   input  logic x1,
   input  logic y0,
   input  logic y1,
   input  logic r,
   input  logic en,
   output logic z0,
   output logic z1
);

   logic d00_d, d11_d, c01_d, c10_d;
   (* keep = "true", dont_touch = "true" *) logic d00_q;
   (* keep = "true", dont_touch = "true" *) logic d11_q;
   (* keep = "true", dont_touch = "true" *) logic c01_q;
   (* keep = "true", dont_touch = "true" *) logic c10_q;

   always_comb begin
      d00_d = x0 & y0;
      d11_d = x1 & y1;
      c01_d = (x0 & y1) ^ r;
      c10_d = (x1 & y0) ^ r;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d00_q <= 1'b0;
         d11_q <= 1'b0;
         c01_q <= 1'b0;
         c10_q <= 1'b0;
      end else if (en) begin
         d00_q <= d00_d;
         d11_q <= d11_d;
         c01_q <= c01_d;
         c10_q <= c10_d;
      end
   end

   // Cross-domain recombination happens only after the registers above.
   assign z0 = d00_q ^ c01_q;
   assign z1 = d11_q ^ c10_q;

endmodule

// File: rtl/masked_gf4_mul_pipe.sv
// Two-share DOM-masked GF(2^2) normal-basis multiplier, two register stages, valid/ready.
// Optional macro GF4_SCL_N_EN scales each product share by N before the output register.
module masked_gf4_mul_pipe
   import masked_gf4_mul_pipe_pkg::*;
#(
   parameter int unsigned LANES = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   masked_gf4_mul_pipe_if.slave  bus
);

   logic en1, en2, accept;
   logic s1_valid_d, s1_valid_q;
   logic out_valid_d, out_valid_q;
   logic [SHARES-1:0][FAC_W*LANES-1:0] z;
   logic [SHARES-1:0][GF4_W*LANES-1:0] p_d, p_q;

   function automatic logic [GF4_W-1:0] compress(input logic [FAC_W-1:0] zf);
      logic [GF4_W-1:0] t;
      t = {zf[1] ^ zf[2], zf[0] ^ zf[2]};
`ifdef GF4_SCL_N_EN
      return {t[0], t[1] ^ t[0]};
`else
      return t;
`endif
   endfunction

   for (genvar g = 0; g < FAC_W * LANES; g++) begin : g_dom
      masked_gf4_mul_pipe_dom_and_2 u_dom (
         .clk   (clk),
         .rst_n (rst_n),
         .x0    (bus.a0_f[g]),
         .x1    (bus.a1_f[g]),
         .y0    (bus.b0_f[g]),
         .y1    (bus.b1_f[g]),
         .r     (bus.rnd[g]),
         .en    (accept),
         .z0    (z[0][g]),
         .z1    (z[1][g])
      );
   end

   always_comb begin
      en2         = !out_valid_q || bus.out_ready;
      en1         = !s1_valid_q || en2;
      accept      = bus.in_valid && en1;
      s1_valid_d  = en1 ? bus.in_valid : s1_valid_q;
      out_valid_d = en2 ? s1_valid_q : out_valid_q;
      p_d         = p_q;
      // Each share is compressed from its own domain only; shares stay separated to the output.
      if (en2 && s1_valid_q) begin
         for (int unsigned s = 0; s < SHARES; s++) begin
            for (int unsigned l = 0; l < LANES; l++) begin
               p_d[s][l*GF4_W +: GF4_W] = compress(z[s][l*FAC_W +: FAC_W]);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         p_q         <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         out_valid_q <= out_valid_d;
         p_q         <= p_d;
      end
   end

   assign bus.in_ready  = en1;
   assign bus.out_valid = out_valid_q;
   assign bus.p0        = p_q[0];
   assign bus.p1        = p_q[1];

endmodule
